// File: rtl/delay_line_ctrl_if.sv
// Sample-strobe, config handshake and RAM address/enable bundle for the delay line controller.
// master drives strobes and config requests; slave (the controller) returns RAM controls and status.
interface delay_line_ctrl_if #(
    parameter int ADDR_W = 13
);
    logic              enable;
    logic              sample_en;
    logic              cfg_req;
    logic [ADDR_W-1:0] cfg_delay;
    logic              cfg_ack;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              echo_valid;
    logic [ADDR_W-1:0] cur_delay;
    logic [1:0]        state;

    modport master (
        output enable, sample_en, cfg_req, cfg_delay,
        input  cfg_ack, wr_en, wr_addr, rd_en, rd_addr, echo_valid, cur_delay, state
    );

    modport slave (
        input  enable, sample_en, cfg_req, cfg_delay,
        output cfg_ack, wr_en, wr_addr, rd_en, rd_addr, echo_valid, cur_delay, state
    );
endinterface

// File: rtl/delay_line_ctrl.sv
// Fill/run sequencer for a RAM delay line: RAM write/read strobes 1 cycle after sample_en, echo_valid 1 later.
// No backpressure on samples; delay changes use a four-phase cfg_req/cfg_ack handshake.
module delay_line_ctrl #(
    parameter int                ADDR_W        = 13,
    parameter logic [ADDR_W-1:0] DEFAULT_DELAY = 13'd4096
) (
    input  logic               sysclk,
    input  logic               reset_n,
    delay_line_ctrl_if.slave   bus
);
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_FILL = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;

    logic [1:0]        state_q;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] fill_cnt;
    logic [ADDR_W-1:0] cur_delay_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              wr_en_q;
    logic              rd_en_q;
    logic              echo_valid_q;
    logic              cfg_ack_q;

    logic              active;
    logic              sample_cyc;
    logic              accept;
    logic              fill_done;
    logic [ADDR_W-1:0] new_delay;

    always_comb begin
        active     = (state_q != ST_IDLE) && bus.enable;
        sample_cyc = active && bus.sample_en;
        accept     = active && bus.cfg_req && !cfg_ack_q;
        fill_done  = (fill_cnt == cur_delay_q - ADDR_W'(1));
        new_delay  = (bus.cfg_delay == '0) ? ADDR_W'(1) : bus.cfg_delay;
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            wr_ptr       <= '0;
            fill_cnt     <= '0;
            cur_delay_q  <= DEFAULT_DELAY;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            echo_valid_q <= 1'b0;
            cfg_ack_q    <= 1'b0;
        end else begin
            wr_en_q      <= sample_cyc;
            rd_en_q      <= sample_cyc && (state_q == ST_RUN);
            // RAM read latency is one cycle, so data lands the cycle after rd_en
            echo_valid_q <= rd_en_q;

            if (sample_cyc) begin
                wr_addr_q <= wr_ptr;
                wr_ptr    <= wr_ptr + ADDR_W'(1);
                if (state_q == ST_RUN) begin
                    rd_addr_q <= wr_ptr - cur_delay_q;
                end
            end

            if (cfg_ack_q && !bus.cfg_req) begin
                cfg_ack_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.enable) begin
                        state_q  <= ST_FILL;
                        fill_cnt <= '0;
                    end
                end
                default: begin
                    if (!bus.enable) begin
                        state_q <= ST_IDLE;
                    end else if (accept) begin
                        // a coincident sample already used the old delay/state above
                        cur_delay_q <= new_delay;
                        fill_cnt    <= '0;
                        state_q     <= ST_FILL;
                        cfg_ack_q   <= 1'b1;
                    end else if ((state_q == ST_FILL) && sample_cyc) begin
                        if (fill_done) begin
                            state_q <= ST_RUN;
                        end else begin
                            fill_cnt <= fill_cnt + ADDR_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.state      = state_q;
    assign bus.cur_delay  = cur_delay_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.echo_valid = echo_valid_q;
    assign bus.cfg_ack    = cfg_ack_q;
endmodule
